// File: rtl/mips_multi_ctrl.sv
// mips_multi_ctrl: multicycle MIPS main control FSM with memory ready handshake and timeout trap
module mips_multi_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_en,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       reg_we,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       trap,
  output logic [3:0] state_o
);
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;
  typedef struct packed {
    logic       pc_en, ir_en, mem_req, mem_we, iord, reg_we, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       trap;
  } ctl_t;
  state_t        state, state_n;
  ctl_t          c;
  logic [CW-1:0] cnt;
  logic          waiting, expired;
  assign waiting = state inside {FETCH, MEMRD, MEMWR};
  assign expired = MEM_TIMEOUT != 0 && waiting && !mem_ready && cnt == LIM;
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? '0 : waiting && !mem_ready && cnt != '1 ? cnt + CW'(1) : cnt;
    end
  always_comb begin
    c       = '0;
    state_n = FETCH;
    case (state)
      FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = 2'd1;
        c.pc_en   = mem_ready;
        c.ir_en   = mem_ready;
        state_n   = mem_ready ? DECODE : expired ? TRAP : FETCH;
      end
      DECODE: begin
        c.alusrcb = 2'd3;
        state_n   = opcode == 6'b100011 || opcode == 6'b101011 ? MEMADR :
                    opcode == 6'b000000 ? EXEC :
                    opcode == 6'b000100 ? BRANCH :
                    opcode == 6'b001000 ? ADDIEX :
                    opcode == 6'b000010 ? JUMP : TRAP;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'd2;
        state_n   = opcode == 6'b100011 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        state_n   = mem_ready ? MEMWB : expired ? TRAP : MEMRD;
      end
      MEMWB: begin
        c.reg_we   = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
        state_n   = mem_ready ? FETCH : expired ? TRAP : MEMWR;
      end
      EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'd2;
        state_n   = ALUWB;
      end
      ALUWB: begin
        c.reg_we = 1'b1;
        c.regdst = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'd1;
        c.pcsrc   = 2'd1;
        c.pc_en   = zero;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'd2;
        state_n   = ADDIWB;
      end
      ADDIWB: c.reg_we = 1'b1;
      JUMP: begin
        c.pcsrc = 2'd2;
        c.pc_en = 1'b1;
      end
      TRAP: c.trap = 1'b1;
      default: ;
    endcase
  end
  assign {pc_en, ir_en, mem_req, mem_we, iord, reg_we, regdst, memtoreg, alusrca,
          alusrcb, aluop, pcsrc, trap} = rst ? '0 : c;
  assign state_o = rst ? 4'd0 : state;
endmodule

// File: tb/tb_mips_multi_ctrl.sv
// tb_mips_multi_ctrl: vector table, directed timeout sequence and randomized trace model
module tb_mips_multi_ctrl;
  localparam int TO = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic [19:0] ga, gb;
  int n_cmp = 0, n_bad = 0;

  mips_multi_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(ga[19]), .ir_en(ga[18]), .mem_req(ga[17]), .mem_we(ga[16]), .iord(ga[15]),
    .reg_we(ga[14]), .regdst(ga[13]), .memtoreg(ga[12]), .alusrca(ga[11]),
    .alusrcb(ga[10:9]), .aluop(ga[8:7]), .pcsrc(ga[6:5]), .trap(ga[4]), .state_o(ga[3:0])
  );

  mips_multi_ctrl #(.MEM_TIMEOUT(TO)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(gb[19]), .ir_en(gb[18]), .mem_req(gb[17]), .mem_we(gb[16]), .iord(gb[15]),
    .reg_we(gb[14]), .regdst(gb[13]), .memtoreg(gb[12]), .alusrca(gb[11]),
    .alusrcb(gb[10:9]), .aluop(gb[8:7]), .pcsrc(gb[6:5]), .trap(gb[4]), .state_o(gb[3:0])
  );

  always #5 clk = ~clk;

  // Output bundle each state must present, taken straight from the control table.
  function automatic logic [19:0] exp_o(int s, logic mr, logic z);
    logic pe = 0, ie = 0, rq = 0, we = 0, io = 0, rw = 0, rd = 0, mt = 0, sa = 0, tr = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (s)
      0:  begin rq = 1; sb = 1; pe = mr; ie = mr; end
      1:  sb = 3;
      2:  begin sa = 1; sb = 2; end
      3:  begin rq = 1; io = 1; end
      4:  begin rw = 1; mt = 1; end
      5:  begin rq = 1; we = 1; io = 1; end
      6:  begin sa = 1; op = 2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 1; ps = 1; pe = z; end
      9:  begin sa = 1; sb = 2; end
      10: rw = 1;
      11: begin ps = 2; pe = 1; end
      12: tr = 1;
      default: ;
    endcase
    return {pe, ie, rq, we, io, rw, rd, mt, sa, sb, op, ps, tr, 4'(s)};
  endfunction

  task automatic chk(string nm, logic [19:0] got, logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic apply(logic r, logic [5:0] op, logic z, logic mr);
    @(negedge clk);
    rst = r; opcode = op; zero = z; mem_ready = mr;
    #1;
  endtask

  typedef struct {logic r; logic [5:0] op; logic z; logic mr; logic [19:0] e;} vec_t;
  vec_t tv[$];
  task automatic add(logic r, logic [5:0] op, logic z, logic mr, int s);
    tv.push_back('{r, op, z, mr, r ? 20'd0 : exp_o(s, mr, z)});
  endtask

  typedef struct {int s; logic mr;} step_t;
  step_t q[$];
  function automatic void push(int s, logic mr);
    q.push_back('{s, mr});
  endfunction

  // A wait state held for w not-ready cycles; more than TO of them ends in TRAP.
  function automatic logic wait_phase(int ws, int w);
    for (int k = 0; k < w && k <= TO; k++) push(ws, 1'b0);
    if (w > TO) begin
      push(12, 1'b0);
      return 1'b1;
    end
    push(ws, 1'b1);
    return 1'b0;
  endfunction

  initial begin
    logic [5:0] ops[9] = '{LW, SW, RT, BEQ, ADDI, J, BAD, 6'b000001, 6'b101010};
    int traps;
    for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0);
    add(0, LW, 0, 0, 1); add(0, LW, 0, 1, 2); add(0, LW, 0, 1, 3); add(0, LW, 0, 0, 4);
    add(0, BEQ, 0, 1, 0); add(0, BEQ, 0, 1, 1); add(0, BEQ, 0, 1, 8);
    add(0, BEQ, 1, 1, 0); add(0, BEQ, 1, 0, 1); add(0, BEQ, 1, 0, 8);
    add(0, BAD, 0, 1, 0); add(0, BAD, 0, 1, 1); add(0, BAD, 0, 1, 12);
    add(0, BAD, 0, 1, 0);
    add(0, SW, 0, 0, 1); add(0, SW, 0, 1, 2);
    for (int i = 0; i < 7; i++) add(0, SW, 0, 0, 5);
    add(0, SW, 0, 1, 5);
    add(0, SW, 0, 0, 0); add(0, RT, 0, 1, 0);
    add(0, RT, 0, 0, 1); add(0, RT, 0, 1, 6); add(0, RT, 0, 0, 7);
    add(0, J, 0, 1, 0); add(0, J, 0, 1, 1); add(0, J, 0, 0, 11);
    add(0, ADDI, 1, 1, 0); add(0, ADDI, 1, 0, 1); add(0, ADDI, 1, 1, 9); add(0, ADDI, 1, 1, 10);
    add(0, 0, 0, 0, 0);
    foreach (tv[i]) begin
      apply(tv[i].r, tv[i].op, tv[i].z, tv[i].mr);
      chk($sformatf("vec%0d", i), ga, tv[i].e);
    end

    // FETCH timeout with a short limit: five idle cycles, then exactly one trap.
    apply(1, 0, 0, 0); apply(1, 0, 0, 0);
    traps = 0;
    for (int i = 0; i < TO + 1; i++) begin
      apply(0, 0, 0, 0);
      chk($sformatf("to_fetch%0d", i), gb, exp_o(0, 0, 0));
      traps += int'(gb[4]) + int'(gb[18]);
    end
    apply(0, 0, 0, 0);
    chk("to_trap", gb, exp_o(12, 0, 0));
    traps += int'(gb[4]);
    apply(0, 0, 0, 0);
    chk("to_back", gb, exp_o(0, 0, 0));
    traps += int'(gb[4]);
    chk("to_pulses", 20'(traps), 20'd1);

    // Randomized instruction stream against a per-instruction trace model.
    apply(1, 0, 0, 1); apply(1, 0, 0, 1);
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic z, to;
      int wf, wm;
      op = ops[$urandom_range(0, 8)];
      z  = 1'($urandom);
      wf = $urandom_range(0, 6);
      wm = $urandom_range(0, 6);
      q.delete();
      to = wait_phase(0, wf);
      if (!to) begin
        push(1, 1'($urandom));
        case (op)
          LW: begin
            push(2, 1'($urandom));
            if (!wait_phase(3, wm)) push(4, 1'($urandom));
          end
          SW: begin
            push(2, 1'($urandom));
            to = wait_phase(5, wm);
          end
          RT:   begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
          BEQ:  push(8, 1'($urandom));
          ADDI: begin push(9, 1'($urandom)); push(10, 1'($urandom)); end
          J:    push(11, 1'($urandom));
          default: push(12, 1'($urandom));
        endcase
      end
      foreach (q[i]) begin
        apply(0, op, z, q[i].mr);
        chk($sformatf("rand%0d_%0d op=%b", n, i, op), gb, exp_o(q[i].s, q[i].mr, z));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
